// File: rtl/wave_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : wave_gen_multi
// Purpose  : Prescaled phase-accumulator waveform generator with four shapes,
//            half-amplitude select, burst length and abort.
// Revision : 1.0
// ============================================================================
module wave_gen_multi #(
    parameter int OUT_W = 8,
    parameter int DIV_W = 10,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [DIV_W-1:0] sw,
    input  logic [1:0]       mode,
    input  logic             sel,
    input  logic [CNT_W-1:0] cycles,
    input  logic             start,
    input  logic             stop,
    output logic [OUT_W-1:0] out,
    output logic             busy,
    output logic             period_tick,
    output logic             done
);

    localparam int HALF = OUT_W / 2;
    localparam logic [OUT_W-1:0] c_STAIR_MASK = {{(OUT_W-HALF){1'b1}}, {HALF{1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pre;
    logic [OUT_W-1:0] r_phase;
    logic [1:0]       r_mode;
    logic             r_sel;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_pcount;
    logic [OUT_W-1:0] r_out;
    logic             r_busy;
    logic             r_tick;
    logic             r_done;

    logic             w_step;
    logic             w_wrap;
    logic [CNT_W-1:0] w_pcount_nxt;
    logic             w_burst_end;
    logic [OUT_W-1:0] w_lin;
    logic [OUT_W-1:0] w_wave;
    logic [OUT_W-1:0] w_sample;

    assign w_step       = (r_pre == r_div);
    assign w_wrap       = w_step && (r_phase == '1);
    assign w_pcount_nxt = r_pcount + 1'b1;
    assign w_burst_end  = w_wrap && (r_cyc != '0) && (w_pcount_nxt == r_cyc);
    assign w_lin        = {r_phase[OUT_W-2:0], 1'b0};

    always_comb begin
        w_wave = r_phase;
        case (r_mode)
            2'b00:   w_wave = r_phase;
            2'b01:   w_wave = r_phase[OUT_W-1] ? ~w_lin : w_lin;
            2'b10:   w_wave = {OUT_W{~r_phase[OUT_W-1]}};
            default: w_wave = r_phase & c_STAIR_MASK;
        endcase
    end

    assign w_sample = r_sel ? (w_wave >> 1) : w_wave;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_pre    <= '0;
            r_phase  <= '0;
            r_mode   <= '0;
            r_sel    <= 1'b0;
            r_cyc    <= '0;
            r_pcount <= '0;
            r_out    <= '0;
            r_busy   <= 1'b0;
            r_tick   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_out  <= '0;
                    r_busy <= 1'b0;
                    if (init) begin
                        r_div <= sw;
                    end
                    if (start && !stop) begin
                        r_state  <= S_RUN;
                        r_phase  <= '0;
                        r_pre    <= '0;
                        r_pcount <= '0;
                        r_mode   <= mode;
                        r_sel    <= sel;
                        r_cyc    <= cycles;
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Sample uses the pre-edge phase, so out trails phase by one clock.
                    r_out <= w_sample;
                    if (w_step) begin
                        r_pre   <= '0;
                        r_phase <= r_phase + 1'b1;
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                    if (w_wrap) begin
                        r_tick   <= 1'b1;
                        r_mode   <= mode;
                        r_sel    <= sel;
                        r_pcount <= w_pcount_nxt;
                    end
                    if (w_burst_end || stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_out   <= '0;
                        r_done  <= w_burst_end;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out         = r_out;
    assign busy        = r_busy;
    assign period_tick = r_tick;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wave_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_gen_multi
// Purpose  : Table-driven scoreboard bench for wave_gen_multi.
// Revision : 1.0
// ============================================================================
module tb_wave_gen_multi;

    localparam int OUT_W = 8;
    localparam int DIV_W = 10;
    localparam int CNT_W = 8;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             init   = 1'b0;
    logic [DIV_W-1:0] sw     = '0;
    logic [1:0]       mode   = '0;
    logic             sel    = 1'b0;
    logic [CNT_W-1:0] cycles = '0;
    logic             start  = 1'b0;
    logic             stop   = 1'b0;
    logic [OUT_W-1:0] out;
    logic             busy;
    logic             period_tick;
    logic             done;

    typedef struct packed {
        logic [7:0] out;
        logic       busy;
        logic       tick;
        logic       done;
    } exp_t;

    typedef struct {
        int         div;
        logic [1:0] md;
        logic       sl;
        int         cyc;
        int         ncyc;
        int         stop_at;
        int         exp_ticks;
        int         exp_dones;
        string      name;
    } vec_t;

    exp_t  sb[$];
    int    n_checks  = 0;
    int    n_errors  = 0;
    int    tick_seen = 0;
    int    done_seen = 0;
    string g_name    = "reset";

    wave_gen_multi #(.OUT_W(OUT_W), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .init        (init),
        .sw          (sw),
        .mode        (mode),
        .sel         (sel),
        .cycles      (cycles),
        .start       (start),
        .stop        (stop),
        .out         (out),
        .busy        (busy),
        .period_tick (period_tick),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (out !== e.out || busy !== e.busy || period_tick !== e.tick || done !== e.done) begin
                n_errors++;
                $display("FAIL %s @%0t: got out=%0d busy=%b tick=%b done=%b, want out=%0d busy=%b tick=%b done=%b",
                         g_name, $time, out, busy, period_tick, done, e.out, e.busy, e.tick, e.done);
            end
            if (period_tick === 1'b1) tick_seen++;
            if (done === 1'b1) done_seen++;
        end
    end

    function automatic logic [7:0] f_ref(int p, logic [1:0] md, logic sl);
        logic [7:0] ph, l, r;
        ph = p[7:0];
        l  = {ph[6:0], 1'b0};
        case (md)
            2'd0:    r = ph;
            2'd1:    r = ph[7] ? ~l : l;
            2'd2:    r = ph[7] ? 8'h00 : 8'hFF;
            default: r = ph & 8'hF0;
        endcase
        return sl ? (r >> 1) : r;
    endfunction

    // Expected outputs after the k-th edge following the start-accepting edge.
    function automatic exp_t exp_at(int k, int div, logic [1:0] md, logic sl, int cyc);
        exp_t e;
        int   d1, ph;
        bit   wrap, fin;
        d1   = div + 1;
        ph   = ((k - 1) / d1) % 256;
        wrap = ((k % d1) == 0) && (ph == 255);
        fin  = wrap && (cyc != 0) && ((k / (256 * d1)) == cyc);
        e.out  = fin ? 8'd0 : f_ref(ph, md, sl);
        e.busy = !fin;
        e.tick = wrap;
        e.done = fin;
        return e;
    endfunction

    task automatic cyc(input exp_t e, input string nm);
        g_name = nm;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic cmp_count(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic start_run(input int div, input logic [1:0] md, input logic sl, input int cy,
                             input bit do_init, input string nm);
        exp_t eb;
        eb      = '0;
        eb.busy = 1'b1;
        if (do_init) begin
            init = 1'b1;
            sw   = div[DIV_W-1:0];
            cyc('0, {nm, " init"});
            init = 1'b0;
        end
        mode      = md;
        sel       = sl;
        cycles    = cy[CNT_W-1:0];
        start     = 1'b1;
        tick_seen = 0;
        done_seen = 0;
        cyc(eb, {nm, " start"});
        start = 1'b0;
    endtask

    task automatic stop_cycle(input string nm);
        stop = 1'b1;
        cyc('0, {nm, " stop"});
        stop = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        bit   live, fin, stp;
        start_run(v.div, v.md, v.sl, v.cyc, 1'b1, v.name);
        live = 1'b1;
        for (int k = 1; k <= v.ncyc; k++) begin
            fin = 1'b0;
            stp = 1'b0;
            e   = '0;
            if (live) begin
                e   = exp_at(k, v.div, v.md, v.sl, v.cyc);
                stp = (k == v.stop_at);
                fin = e.done;
                if (stp) begin
                    e.out  = '0;
                    e.busy = 1'b0;
                end
            end
            stop = stp;
            cyc(e, v.name);
            stop = 1'b0;
            if (stp || fin) live = 1'b0;
        end
        if (live) stop_cycle(v.name);
        cmp_count({v.name, " ticks"}, tick_seen, v.exp_ticks);
        cmp_count({v.name, " dones"}, done_seen, v.exp_dones);
    endtask

    vec_t vecs[8];
    exp_t e;

    initial begin
        //          div md    sl    cyc ncyc stop ticks dones name
        vecs[0] = '{0, 2'd0, 1'b0, 0, 600, 0,   2, 0, "saw_div0"};
        vecs[1] = '{3, 2'd0, 1'b0, 0, 1100, 0,  1, 0, "saw_div3"};
        vecs[2] = '{0, 2'd1, 1'b0, 2, 520, 0,   2, 1, "tri_burst2"};
        vecs[3] = '{0, 2'd2, 1'b1, 0, 300, 0,   1, 0, "square_half"};
        vecs[4] = '{0, 2'd3, 1'b0, 1, 260, 0,   1, 1, "stair_burst1"};
        vecs[5] = '{1, 2'd1, 1'b1, 0, 100, 51,  0, 0, "tri_half_stop"};
        vecs[6] = '{0, 2'd0, 1'b0, 0, 100, 52,  0, 0, "stop_at_out50"};
        vecs[7] = '{0, 2'd0, 1'b0, 3, 800, 768, 3, 1, "stop_on_done"};

        rst = 1'b1;
        cyc('0, "reset");
        cyc('0, "reset hold");
        rst = 1'b0;

        start = 1'b1;
        stop  = 1'b1;
        cyc('0, "start_stop");
        start = 1'b0;
        stop  = 1'b0;
        cyc('0, "start_stop idle");

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // init while running must not disturb the prescaler.
        start_run(0, 2'd0, 1'b0, 0, 1'b1, "init_in_run");
        for (int k = 1; k <= 40; k++) begin
            init = (k == 10);
            sw   = 10'd7;
            cyc(exp_at(k, 0, 2'd0, 1'b0, 0), "init_in_run");
        end
        init = 1'b0;
        stop_cycle("init_in_run");

        // Mode change mid-period is deferred to the next wrap.
        start_run(0, 2'd2, 1'b0, 0, 1'b1, "mode_change");
        for (int k = 1; k <= 300; k++) begin
            if (k == 100) mode = 2'd0;
            cyc(exp_at(k, 0, (k <= 256) ? 2'd2 : 2'd0, 1'b0, 0), "mode_change");
        end
        stop_cycle("mode_change");
        cmp_count("mode_change ticks", tick_seen, 1);

        // Reset during RUN clears the prescaler reload too.
        start_run(2, 2'd0, 1'b0, 0, 1'b1, "reset_mid_run");
        for (int k = 1; k <= 30; k++) cyc(exp_at(k, 2, 2'd0, 1'b0, 0), "reset_mid_run");
        rst = 1'b1;
        cyc('0, "reset_mid_run rst");
        rst = 1'b0;
        start_run(0, 2'd0, 1'b0, 0, 1'b0, "after_reset");
        for (int k = 1; k <= 10; k++) cyc(exp_at(k, 0, 2'd0, 1'b0, 0), "after_reset");
        stop_cycle("after_reset");
        cmp_count("after_reset dones", done_seen, 0);

        cmp_count("scoreboard drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wave_gen_multi.md
Name: wave_gen_multi

Overview:
- Parametrised multi-mode waveform generator for the lab top level. Successor to the fixed 8-bit, single-mode generator.
- Adds the following over the previous generation:
  - generic output width;
  - programmable clock prescaler loaded from switches on init;
  - four waveform modes, latched at period boundaries;
  - half-amplitude select;
  - burst mode: run N periods, then stop;
  - abort input and status outputs.

Parameters:
- OUT_W, 8, output sample width and phase accumulator width (>=4, even).
- DIV_W, 10, prescaler reload width; matches the switch bank.
- CNT_W, 8, burst period-count width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- init  in  1  load div_reg from sw (IDLE only)
- sw  in  DIV_W  prescaler reload value
- mode  in  2  waveform select: 00 saw, 01 triangle, 10 square, 11 staircase
- sel  in  1  1 = half amplitude (out shifted right by 1)
- cycles  in  CNT_W  burst length in periods; 0 = continuous
- start  in  1  begin generation (IDLE only)
- stop  in  1  abort generation
- out  out  OUT_W  registered sample
- busy  out  1  high in RUN
- period_tick  out  1  one-cycle pulse on each phase wrap
- done  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE. All of the following go to 0: div_reg, pre, phase, mode_q, sel_q, cyc_q, pcount, out, busy, period_tick, done. Reset mid-RUN aborts with no done pulse.
- IDLE:
  - init=1 -> div_reg<=sw.
  - start=1 and stop=0 -> state<=RUN, phase<=0, pre<=0, pcount<=0, mode_q<=mode, sel_q<=sel, cyc_q<=cycles.
  - out is held at 0.
- RUN:
  - init and start are ignored.
  - Each clk: if pre==div_reg then pre<=0 and a step occurs; else pre<=pre+1.
  - A step advances phase by 1 every (div_reg+1) clocks. div_reg=0 steps every clock.
- Step with phase==2^OUT_W-1 (wrap):
  - phase<=0; period_tick<=1 for one cycle.
  - mode_q<=mode and sel_q<=sel, so mode/sel changes take effect only at period boundaries.
  - pcount<=pcount+1.
  - If cyc_q!=0 and pcount+1==cyc_q: state<=IDLE, busy<=0, out<=0, done<=1 for one cycle. This takes priority over the tick-driven reload.
- pcount wraps silently in continuous mode.
- Waveform f(p), with M = p[OUT_W-1] and L = {p[OUT_W-2:0],1'b0}:
  - saw: p
  - triangle: M ? ~L : L
  - square: all ones if M==0, else 0
  - staircase: p with its low OUT_W/2 bits cleared
- Output: in RUN, out<=f(phase) >> sel_q, using the pre-edge phase. out therefore lags phase by one clock.
- stop=1 in RUN: next edge state<=IDLE, out<=0, busy<=0, no done.
- start and stop together in IDLE: stop wins; remain IDLE.
- stop coinciding with burst completion: done still pulses.
- busy is registered: it goes 1 on the edge that accepts start and 0 on the edge that enters IDLE.

Test Plan:
1. rst; init with sw=0; start with mode=00, sel=0, cycles=0 -> out = 0,0,1,2,... incrementing every clk. period_tick pulses every 256 clks. busy stays 1.
2. init with sw=3; saw; start -> phase steps every 4 clks. out holds each value for 4 clks. First period_tick occurs 1024 clks after start.
3. sw=0, cycles=2, mode=01 -> out follows the triangle 0,2,4,...,254,255,253,...,1. After 512 steps: done pulses once, busy=0, out=0. Two period_ticks in total.
4. mode=10, sel=1, sw=0 -> out = 127 for 128 clks, then 0 for 128 clks. Changing mode to 00 mid-period takes effect only after the next period_tick.
5. Assert stop at out=50 -> next edge out=0, busy=0, no done. start and stop together in IDLE -> busy stays 0. init during RUN -> div_reg unchanged.
6. rst asserted mid-RUN -> on the next edge all outputs are 0, state is IDLE, div_reg=0.
